// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract sequencer: one 32-bit adder/subtractor slice reused over WORDS cycles, LSW first.
// Define ADDSUB_SEQ_OVF_EN to add the signed-overflow output Ovf.
module addsub_seq_ctrl #(
  parameter int WORDS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*WORDS-1:0] A,
  input  logic [32*WORDS-1:0] B,
  input  logic                Sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*WORDS-1:0] Out,
  output logic                Cout,
`ifdef ADDSUB_SEQ_OVF_EN
  output logic                Ovf,
`endif
  output logic                busy
);
  localparam int W     = 32*WORDS;
  localparam int IDX_W = $clog2(WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS-1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W+4:0] base;
  logic             carry;
  logic [W-1:0]     a_p0;
  logic [W-1:0]     b_p0;
  logic             sub_p0;
  logic [31:0]      slice_a;
  logic [31:0]      slice_b;
  logic [31:0]      slice_sum;
  logic             slice_cout;

  // Behaviour of the shared gate-level slice: B is inverted by Cin, which is also the carry-in.
  function automatic logic [32:0] slice_addsub(input logic [31:0] a, input logic [31:0] b,
                                               input logic cin);
    logic [31:0] b_int;
    b_int = b ^ {32{cin}};
    return {1'b0, a} + {1'b0, b_int} + {32'd0, cin};
  endfunction

  // Pre-XOR with Sub^carry cancels the slice's own inversion, leaving B^Sub at the adder.
  always_comb begin
    base    = {idx, 5'd0};
    slice_a = a_p0[base +: 32];
    slice_b = b_p0[base +: 32] ^ {32{sub_p0 ^ carry}};
    {slice_cout, slice_sum} = slice_addsub(slice_a, slice_b, carry);
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  // Operand capture stage: loaded only on acceptance, frozen while the operation runs.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_p0   <= A;
      b_p0   <= B;
      sub_p0 <= Sub;
    end
  end

  // Sequencing stage: one word per RUN cycle, carry chained through a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      Out   <= '0;
      Cout  <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      Ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx   <= '0;
            carry <= Sub;
            state <= RUN;
          end
        end
        RUN: begin
          Out[base +: 32] <= slice_sum;
          carry           <= slice_cout;
          idx             <= idx + 1'b1;
          if (idx == LAST) begin
            Cout  <= slice_cout;
`ifdef ADDSUB_SEQ_OVF_EN
            Ovf   <= (slice_a[31] == (b_p0[W-1] ^ sub_p0)) && (slice_sum[31] != slice_a[31]);
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
`ifdef ADDSUB_SEQ_OVF_EN
            Ovf   <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl: directed vectors, backpressure, async abort, randomised WORDS=1/2/4 regression.
// Ovf checks are compiled in when ADDSUB_SEQ_OVF_EN is defined.
module tb_addsub_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   out_ready;
  logic [2:0]   sub_in;
  wire  [2:0]   in_ready;
  wire  [2:0]   out_valid;
  wire  [2:0]   busy;
  wire  [2:0]   cout;
`ifdef ADDSUB_SEQ_OVF_EN
  wire  [2:0]   ovf;
`endif
  logic [31:0]  a1, b1;
  logic [63:0]  a2, b2;
  logic [127:0] a4, b4;
  wire  [31:0]  out1;
  wire  [63:0]  out2;
  wire  [127:0] out4;

  int errors = 0;
  int checks = 0;

  addsub_seq_ctrl #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(a1), .B(b1), .Sub(sub_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .Out(out1), .Cout(cout[0]),
`ifdef ADDSUB_SEQ_OVF_EN
    .Ovf(ovf[0]),
`endif
    .busy(busy[0]));

  addsub_seq_ctrl #(.WORDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(a2), .B(b2), .Sub(sub_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .Out(out2), .Cout(cout[1]),
`ifdef ADDSUB_SEQ_OVF_EN
    .Ovf(ovf[1]),
`endif
    .busy(busy[1]));

  addsub_seq_ctrl #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .A(a4), .B(b4), .Sub(sub_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .Out(out4), .Cout(cout[2]),
`ifdef ADDSUB_SEQ_OVF_EN
    .Ovf(ovf[2]),
`endif
    .busy(busy[2]));

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         sub;
    logic [127:0] out;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  function automatic int nw(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [127:0] mask(input int k);
    logic [127:0] m;
    m = '1;
    return m >> (128 - 32*nw(k));
  endfunction

  function automatic logic [127:0] get_out(input int k);
    case (k)
      0:       return {96'd0, out1};
      1:       return {64'd0, out2};
      default: return out4;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] pick(input int k);
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return mask(k);
      2:       return mask(k) >> 1;
      3:       return mask(k) & ~(mask(k) >> 1);
      default: return rnd128() & mask(k);
    endcase
  endfunction

  // Reference: unsigned W-bit add/subtract, Cout as carry or no-borrow, Ovf from exact signed result.
  function automatic void model(input int k, input logic [127:0] a_in, input logic [127:0] b_in,
                                input logic sub, output logic [127:0] o, output logic c,
                                output logic v);
    int w;
    logic [127:0] a, b;
    logic [128:0] s;
    logic signed [131:0] sa, sb, sr, lim;
    w = 32*nw(k);
    a = a_in & mask(k);
    b = b_in & mask(k);
    if (sub) begin
      o = (a - b) & mask(k);
      c = (a >= b);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      o = s[127:0] & mask(k);
      c = s[w];
    end
    sa = $signed({4'b0, a});
    sb = $signed({4'b0, b});
    if (a[w-1]) sa = sa - (132'sd1 <<< w);
    if (b[w-1]) sb = sb - (132'sd1 <<< w);
    sr  = sub ? (sa - sb) : (sa + sb);
    lim = 132'sd1 <<< (w-1);
    v   = (sr >= lim) || (sr < -lim);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int k, input logic [127:0] a, input logic [127:0] b,
                         input logic s);
    case (k)
      0:       begin a1 = a[31:0]; b1 = b[31:0]; end
      1:       begin a2 = a[63:0]; b2 = b[63:0]; end
      default: begin a4 = a;       b4 = b;       end
    endcase
    sub_in[k] = s;
  endtask

  task automatic wait_valid(input int k, input int lim, input bit scramble, output int n);
    n = 0;
    while (!out_valid[k] && n < lim) begin
      if (scramble) begin
        set_ops(k, rnd128(), rnd128(), 1'($urandom));
        in_valid[k] = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (!out_valid[k]) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: out_valid never rose within %0d cycles", k, lim);
    end
  endtask

  // One full transaction with throttled in_valid/out_ready and scrambled inputs while busy.
  task automatic run_op(input int k, input logic [127:0] a, input logic [127:0] b,
                        input logic sub, input logic [127:0] eo, input logic ec,
                        input logic eov);
    int n;
    int hold;
    string tag;
    tag = $sformatf("w%0d sub%0b ovf_exp%0b", nw(k), sub, eov);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    set_ops(k, a, b, sub);
    in_valid[k] = 1'b1;
    @(negedge clk);
    chk({"accept busy ", tag}, busy[k], 1'b1);
    chk({"accept in_ready ", tag}, in_ready[k], 1'b0);
    wait_valid(k, 20, 1'b1, n);
    if (!out_valid[k]) begin
      in_valid[k] = 1'b0;
      return;
    end
    chk({"latency ", tag}, n, nw(k));
    hold = $urandom_range(0, 3);
    for (int i = 0; i <= hold; i++) begin
      chk({"out ", tag}, get_out(k), eo & mask(k));
      chk({"cout ", tag}, cout[k], ec);
`ifdef ADDSUB_SEQ_OVF_EN
      chk({"ovf ", tag}, ovf[k], eov);
`endif
      if (i == hold) begin
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b0;
      end else begin
        set_ops(k, rnd128(), rnd128(), 1'($urandom));
        in_valid[k] = 1'($urandom);
      end
      @(negedge clk);
    end
    out_ready[k] = 1'b0;
    chk({"out_valid drop ", tag}, out_valid[k], 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ra, rb, eo;
    logic rs, ec, ev;
    int n;

    vecs[0] = '{128'h00000000_FFFFFFFF, 128'h1, 1'b0, 128'h00000001_00000000, 1'b0, 1'b0};
    vecs[1] = '{128'h0, 128'h1, 1'b1, 128'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0};
    vecs[2] = '{128'h5, 128'h3, 1'b1, 128'h2, 1'b1, 1'b0};
    vecs[3] = '{128'hFFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 128'h0, 1'b1, 1'b0};
    vecs[4] = '{128'h7FFFFFFF_FFFFFFFF, 128'h1, 1'b0, 128'h80000000_00000000, 1'b0, 1'b1};
    vecs[5] = '{128'h80000000_00000000, 128'h1, 1'b1, 128'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1};

    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    sub_in = '0;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset in_ready w%0d", nw(k)), in_ready[k], 1'b1);
      chk($sformatf("reset out_valid w%0d", nw(k)), out_valid[k], 1'b0);
      chk($sformatf("reset busy w%0d", nw(k)), busy[k], 1'b0);
      chk($sformatf("reset out w%0d", nw(k)), get_out(k), 128'h0);
      chk($sformatf("reset cout w%0d", nw(k)), cout[k], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_op(1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].out, vecs[i].cout, vecs[i].ovf);

    // Backpressure: result held 5 cycles while new operands are offered and refused.
    set_ops(1, 128'd3, 128'd4, 1'b0);
    in_valid[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    wait_valid(1, 20, 1'b0, n);
    set_ops(1, 128'd100, 128'd200, 1'b0);
    in_valid[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp out held", get_out(1), 128'd7);
      chk("bp cout held", cout[1], 1'b0);
      chk("bp in_ready low", in_ready[1], 1'b0);
      chk("bp out_valid high", out_valid[1], 1'b1);
      if (i == 5) out_ready[1] = 1'b1;
      @(negedge clk);
    end
    out_ready[1] = 1'b0;
    chk("bp back to idle in_ready", in_ready[1], 1'b1);
    chk("bp back to idle out_valid", out_valid[1], 1'b0);
    @(negedge clk);
    in_valid[1] = 1'b0;
    chk("bp new op accepted", busy[1], 1'b1);
    wait_valid(1, 20, 1'b0, n);
    chk("bp new op out", get_out(1), 128'd300);
    chk("bp new op cout", cout[1], 1'b0);
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;

    // Asynchronous abort in the middle of a WORDS=4 operation.
    set_ops(2, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0, 1'b0);
    in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort busy before reset", busy[2], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid[2], 1'b0);
    chk("abort in_ready", in_ready[2], 1'b1);
    chk("abort busy", busy[2], 1'b0);
    chk("abort out", get_out(2), 128'h0);
    chk("abort cout", cout[2], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2, 128'd1, 128'd1, 1'b0, 128'd2, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 334; i++) begin
        ra = pick(k);
        rb = ($urandom_range(0, 3) == 0) ? 128'd1 : pick(k);
        rs = 1'($urandom);
        model(k, ra, rb, rs, eo, ec, ev);
        run_op(k, ra, rb, rs, eo, ec, ev);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
